// File: rtl/key_conditioner_if.sv
// Push-button bundle between the raw board keys and the conditioned key events.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;          // raw asynchronous buttons
  logic [N_KEYS-1:0] key_level;    // debounced level, 1 = pressed
  logic [N_KEYS-1:0] key_press;    // 1-cycle pulse on accepted press
  logic [N_KEYS-1:0] key_release;  // 1-cycle pulse on accepted release
  logic [N_KEYS-1:0] key_repeat;   // 1-cycle auto-repeat pulse while held
  logic [N_KEYS-1:0] key_event;    // press or repeat, drives increment logic

  // Button side: drives raw keys, consumes conditioned events.
  modport master (
    output KEY,
    input  key_level, key_press, key_release, key_repeat, key_event
  );

  // Conditioner side: samples raw keys, produces conditioned events.
  modport slave (
    input  KEY,
    output key_level, key_press, key_release, key_repeat, key_event
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer and auto-repeat generator for board push-buttons.
// Each channel is independent; every output is registered on CLOCK_50.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic              CLOCK_50,
  input logic              reset,
  key_conditioner_if.slave kif
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic             RAW_IDLE    = (ACTIVE_LOW != 0);
  localparam logic             RPT_ON      = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [N_KEYS-1:0] level_w;
  logic [N_KEYS-1:0] press_w;
  logic [N_KEYS-1:0] release_w;
  logic [N_KEYS-1:0] repeat_w;
  logic [N_KEYS-1:0] event_w;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             sync_n_q;
    logic             sync_n_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    logic             event_q;
    rpt_state_e       rpt_state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             mismatch_c;
    logic             accept_c;
    logic             press_c;
    logic             release_c;

    // Polarity normalization: sync_n is 1 whenever the key is pressed.
    assign sync_n_d   = RAW_IDLE ? ~sync2_q : sync2_q;
    assign mismatch_c = (sync_n_q != level_q);
    assign accept_c   = mismatch_c && (deb_cnt_q == DEB_LAST);
    assign press_c    = accept_c && !level_q;
    assign release_c  = accept_c && level_q;

    // Synchronizer, debounce counter, accepted level and press/release pulses.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        sync1_q   <= RAW_IDLE;
        sync2_q   <= RAW_IDLE;
        sync_n_q  <= 1'b0;
        deb_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= kif.KEY[i];
        sync2_q   <= sync1_q;
        sync_n_q  <= sync_n_d;
        press_q   <= press_c;
        release_q <= release_c;
        if (!mismatch_c) begin
          deb_cnt_q <= '0;
        end else if (accept_c) begin
          deb_cnt_q <= '0;
          level_q   <= ~level_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end
    end

    // Auto-repeat FSM; a release in the same cycle always wins over a repeat.
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        rpt_state_q <= RPT_IDLE;
        rpt_cnt_q   <= '0;
        repeat_q    <= 1'b0;
        event_q     <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        event_q  <= press_c;
        if (!RPT_ON || release_c) begin
          rpt_state_q <= RPT_IDLE;
          rpt_cnt_q   <= '0;
        end else if (press_c) begin
          rpt_state_q <= RPT_DELAY;
          rpt_cnt_q   <= '0;
        end else begin
          case (rpt_state_q)
            RPT_DELAY: begin
              if (rpt_cnt_q == DELAY_LAST) begin
                repeat_q    <= 1'b1;
                event_q     <= 1'b1;
                rpt_state_q <= RPT_REPEAT;
                rpt_cnt_q   <= '0;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rpt_cnt_q == PERIOD_LAST) begin
                repeat_q  <= 1'b1;
                event_q   <= 1'b1;
                rpt_cnt_q <= '0;
              end else begin
                rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
              end
            end
            default: begin
              rpt_state_q <= RPT_IDLE;
              rpt_cnt_q   <= '0;
            end
          endcase
        end
      end
    end

    assign level_w[i]   = level_q;
    assign press_w[i]   = press_q;
    assign release_w[i] = release_q;
    assign repeat_w[i]  = repeat_q;
    assign event_w[i]   = event_q;
  end

  assign kif.key_level   = level_w;
  assign kif.key_press   = press_w;
  assign kif.key_release = release_w;
  assign kif.key_repeat  = repeat_w;
  assign kif.key_event   = event_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
// Edge k = 0 is the first rising edge that samples a new raw KEY value.
module tb_key_conditioner;
  localparam int unsigned NK = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .kif      (kif)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NK-1:0] oh(input int idx, input bit c);
    return c ? (NK'(1) << idx) : '0;
  endfunction

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
  endtask

  task automatic chk_all(input string tag, input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                         input logic [NK-1:0] rel, input logic [NK-1:0] rpt);
    chk({tag, ".level"},   kif.key_level,   lvl);
    chk({tag, ".press"},   kif.key_press,   prs);
    chk({tag, ".release"}, kif.key_release, rel);
    chk({tag, ".repeat"},  kif.key_repeat,  rpt);
    chk({tag, ".event"},   kif.key_event,   prs | rpt);
  endtask

  // Clean press then clean release on one key; press and release land on edge 6.
  task automatic press_release(input int idx, input string tag);
    kif.KEY[idx] = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk_all({tag, ".press"}, oh(idx, k >= 6), oh(idx, k == 6), '0, '0);
    end
    kif.KEY[idx] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk_all({tag, ".rel"}, oh(idx, k < 6), '0, oh(idx, k == 6), '0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    kif.KEY = '1;
    step();
    step();
    step();
    chk_all("reset", '0, '0, '0, '0);
    reset = 1'b0;
    step();
    step();
    chk_all("idle", '0, '0, '0, '0);

    // Clean press/release on KEY[0] and a release check on KEY[2].
    press_release(0, "clean0");
    press_release(2, "release2");

    // Bounce: KEY[1] low two cycles, high two cycles, ending high.
    for (int t = 0; t < 20; t++) begin
      kif.KEY[1] = (((t / 2) % 2) != 0);
      step();
      chk_all("bounce", '0, '0, '0, '0);
    end
    press_release(1, "settle1");

    // Auto-repeat on KEY[3]: press at 6, repeats 16..41 every 5, release accepted at 46.
    kif.KEY[3] = 1'b0;
    for (int k = 0; k <= 56; k++) begin
      step();
      chk_all("repeat3", oh(3, k >= 6 && k < 46), oh(3, k == 6), oh(3, k == 46),
              oh(3, k >= 16 && k <= 41 && ((k - 16) % 5) == 0));
      if (k == 39) kif.KEY[3] = 1'b1;
    end

    // Reset while KEY[0] sits in the repeat phase, key kept held.
    kif.KEY[0] = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      step();
      chk_all("rstrpt.pre", oh(0, k >= 6), oh(0, k == 6), '0, oh(0, k == 16));
    end
    reset = 1'b1;
    step();
    chk_all("rstrpt.mid", '0, '0, '0, '0);
    reset = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      chk_all("rstrpt.post", oh(0, k >= 6), oh(0, k == 6), '0, '0);
    end
    kif.KEY[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      chk_all("rstrpt.rel", oh(0, k < 6), '0, oh(0, k == 6), '0);
    end

    // Simultaneous press of KEY[0] and KEY[3]; KEY[0] released early, KEY[3] keeps repeating.
    kif.KEY[0] = 1'b0;
    kif.KEY[3] = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      step();
      chk_all("simul",
              oh(0, k >= 6 && k < 16) | oh(3, k >= 6 && k < 35),
              oh(0, k == 6) | oh(3, k == 6),
              oh(0, k == 16) | oh(3, k == 35),
              oh(3, k >= 16 && k <= 31 && ((k - 16) % 5) == 0));
      if (k == 9)  kif.KEY[0] = 1'b1;
      if (k == 28) kif.KEY[3] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
